// File: rtl/iomem_dma_if.sv
// Command and iomem bus bundle for iomem_dma. The error signal exists only
// when IOMEM_DMA_TIMEOUT_EN is defined.
interface iomem_dma_if;
  logic        cmd_start;
  logic        cmd_abort;
  logic [31:0] cmd_src;
  logic [31:0] cmd_dst;
  logic [15:0] cmd_len;
  logic        busy;
  logic        done;
  logic [15:0] words_done;
  logic        iomem_valid;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
`ifdef IOMEM_DMA_TIMEOUT_EN
  logic        error;
`endif

  modport master (
    input  cmd_start, cmd_abort, cmd_src, cmd_dst, cmd_len, iomem_ready, iomem_rdata,
    output busy, done, words_done, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
`ifdef IOMEM_DMA_TIMEOUT_EN
    , output error
`endif
  );

  modport slave (
    output cmd_start, cmd_abort, cmd_src, cmd_dst, cmd_len, iomem_ready, iomem_rdata,
    input  busy, done, words_done, iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
`ifdef IOMEM_DMA_TIMEOUT_EN
    , input error
`endif
  );
endinterface

// File: rtl/iomem_dma.sv
// Word-copy DMA over the iomem bus: one read then one write per word.
// Define IOMEM_DMA_TIMEOUT_EN to add a ready-wait timeout and error output.
module iomem_dma #(
  parameter int unsigned DST_INC        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  iomem_dma_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, FIN} state_t;

  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFC;

  state_t      state;
  logic [31:0] src;
  logic [31:0] dst;
  logic [31:0] data_buf;
  logic [15:0] len;
  logic        abort_pend;
  logic        hs;

  assign hs = bus.iomem_valid && bus.iomem_ready;

`ifdef IOMEM_DMA_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;
`endif

  // NOTE: the reset is synchronous, so it lives inside the clocked branch and
  // every register, including the data buffer, gets an explicit value.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= IDLE;
      src              <= '0;
      dst              <= '0;
      len              <= '0;
      data_buf         <= '0;
      abort_pend       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.words_done   <= '0;
      bus.iomem_valid  <= 1'b0;
      bus.iomem_wstrb  <= '0;
      bus.iomem_addr   <= '0;
      bus.iomem_wdata  <= '0;
`ifdef IOMEM_DMA_TIMEOUT_EN
      wait_cnt         <= '0;
      bus.error        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the case
      // below overrides them because the last scheduled update wins.
      bus.done <= 1'b0;
      if (state != IDLE && bus.cmd_abort) abort_pend <= 1'b1;
`ifdef IOMEM_DMA_TIMEOUT_EN
      if (bus.iomem_valid && !bus.iomem_ready) wait_cnt <= wait_cnt + 1'b1;
`endif

      unique case (state)
        IDLE: begin
          if (bus.cmd_start) begin
            src            <= bus.cmd_src & ADDR_MASK;
            dst            <= bus.cmd_dst & ADDR_MASK;
            len            <= bus.cmd_len;
            bus.words_done <= '0;
            bus.busy       <= 1'b1;
`ifdef IOMEM_DMA_TIMEOUT_EN
            bus.error      <= 1'b0;
            wait_cnt       <= '0;
`endif
            if (bus.cmd_len == 16'd0) begin
              state <= FIN;
            end else begin
              bus.iomem_valid <= 1'b1;
              bus.iomem_addr  <= bus.cmd_src & ADDR_MASK;
              bus.iomem_wstrb <= 4'h0;
              state           <= RD;
            end
          end
        end

        RD: begin
          if (hs) begin
            data_buf        <= bus.iomem_rdata;
            src             <= src + 32'd4;
            bus.iomem_valid <= 1'b0;
            bus.iomem_addr  <= '0;
            state           <= RD_GAP;
          end
`ifdef IOMEM_DMA_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            bus.iomem_valid <= 1'b0;
            bus.iomem_addr  <= '0;
            bus.error       <= 1'b1;
            state           <= FIN;
          end
`endif
        end

        RD_GAP: begin
          bus.iomem_valid <= 1'b1;
          bus.iomem_addr  <= dst;
          bus.iomem_wstrb <= 4'hF;
          bus.iomem_wdata <= data_buf;
`ifdef IOMEM_DMA_TIMEOUT_EN
          wait_cnt        <= '0;
`endif
          state           <= WR;
        end

        WR: begin
          if (hs) begin
            bus.iomem_valid <= 1'b0;
            bus.iomem_addr  <= '0;
            bus.iomem_wstrb <= '0;
            bus.iomem_wdata <= '0;
            bus.words_done  <= bus.words_done + 16'd1;
            if (DST_INC != 0) dst <= dst + 32'd4;
            state           <= WR_GAP;
          end
`ifdef IOMEM_DMA_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            bus.iomem_valid <= 1'b0;
            bus.iomem_addr  <= '0;
            bus.iomem_wstrb <= '0;
            bus.iomem_wdata <= '0;
            bus.error       <= 1'b1;
            state           <= FIN;
          end
`endif
        end

        WR_GAP: begin
          // An abort arriving in this very cycle also ends the copy here.
          if (bus.words_done == len || abort_pend || bus.cmd_abort) begin
            state <= FIN;
          end else begin
            bus.iomem_valid <= 1'b1;
            bus.iomem_addr  <= src;
            bus.iomem_wstrb <= 4'h0;
`ifdef IOMEM_DMA_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
            state           <= RD;
          end
        end

        FIN: begin
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_dma.sv
// Scoreboard bench for iomem_dma: directed copies, expected bus transactions
// queued by the stimulus and checked by a separate bus monitor.
module tb_iomem_dma;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk;
  logic        resetn;
  logic        sel;
  logic        cmd_start, cmd_abort;
  logic [31:0] cmd_src, cmd_dst;
  logic [15:0] cmd_len;
  logic        ready;
  logic [31:0] rdata;

  int  wait_states;
  bit  never_ready;
  bit  hold_wr;
  bit  chk_en;
  int  wcnt;
  int  pass_cnt;
  int  total_cnt;
  int  done_cnt;
  int  valid_cycles;
  txn_t exp_q[$];

  iomem_dma_if if0 ();
  iomem_dma_if if1 ();

  iomem_dma #(.DST_INC(1)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  iomem_dma #(.DST_INC(0)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));

  assign if0.cmd_start   = cmd_start & ~sel;
  assign if1.cmd_start   = cmd_start & sel;
  assign if0.cmd_abort   = cmd_abort & ~sel;
  assign if1.cmd_abort   = cmd_abort & sel;
  assign if0.cmd_src     = cmd_src;
  assign if1.cmd_src     = cmd_src;
  assign if0.cmd_dst     = cmd_dst;
  assign if1.cmd_dst     = cmd_dst;
  assign if0.cmd_len     = cmd_len;
  assign if1.cmd_len     = cmd_len;
  assign if0.iomem_ready = ready & ~sel;
  assign if1.iomem_ready = ready & sel;
  assign if0.iomem_rdata = rdata;
  assign if1.iomem_rdata = rdata;

  logic        m_valid, m_busy, m_done;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  logic [15:0] m_words;
  assign m_valid = sel ? if1.iomem_valid : if0.iomem_valid;
  assign m_wstrb = sel ? if1.iomem_wstrb : if0.iomem_wstrb;
  assign m_addr  = sel ? if1.iomem_addr  : if0.iomem_addr;
  assign m_wdata = sel ? if1.iomem_wdata : if0.iomem_wdata;
  assign m_busy  = sel ? if1.busy        : if0.busy;
  assign m_done  = sel ? if1.done        : if0.done;
  assign m_words = sel ? if1.words_done  : if0.words_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic exp_rd(input logic [31:0] a);
    txn_t t;
    t.wr = 1'b0; t.addr = a; t.data = '0;
    exp_q.push_back(t);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = 1'b1; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  // Responder: data read from address A is A + 0x1000_0000.
  always @(negedge clk) begin
    if (m_valid === 1'b1 && !never_ready && !(hold_wr && m_wstrb == 4'hF)) begin
      if (wcnt >= wait_states) begin
        ready = 1'b1;
        rdata = m_addr + 32'h1000_0000;
      end else begin
        ready = 1'b0;
        wcnt++;
      end
    end else begin
      ready = 1'b0;
      if (m_valid !== 1'b1) wcnt = 0;
    end
  end

  // Monitor: a handshake completes at the next rising edge when valid&ready.
  always @(negedge clk) begin
    txn_t e;
    #1;
    if (chk_en) begin
      if (m_valid && ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL txn_extra: got addr 0x%08h wstrb %h, expected no transaction", m_addr, m_wstrb);
        end else begin
          e = exp_q.pop_front();
          check("txn_wstrb", {28'd0, m_wstrb}, e.wr ? 32'hF : 32'h0);
          check("txn_addr", m_addr, e.addr);
          if (e.wr) check("txn_wdata", m_wdata, e.data);
        end
      end
      if (!m_valid) check("idle_bus_zero", m_addr | {28'd0, m_wstrb}, 32'h0);
      if (m_valid) valid_cycles++;
      if (m_done) done_cnt++;
    end
  end

  task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    cmd_src = s; cmd_dst = d; cmd_len = l;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!m_done && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", {31'd0, m_done}, 32'd1);
  endtask

  task automatic finish_run(input string tag, input int d0, input logic [15:0] words);
    repeat (2) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - d0, 32'd1);
    check({tag, "_words_done"}, {16'd0, m_words}, {16'd0, words});
    check({tag, "_busy_clear"}, {31'd0, m_busy}, 32'd0);
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int lat, d0, v0, n;
    resetn = 1'b0; sel = 1'b0;
    cmd_start = 1'b0; cmd_abort = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    ready = 1'b0; rdata = '0;
    wait_states = 0; never_ready = 1'b0; hold_wr = 1'b0; chk_en = 1'b0;
    wcnt = 0; pass_cnt = 0; total_cnt = 0; done_cnt = 0; valid_cycles = 0;

    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, if0.iomem_valid}, 32'd0);
    check("rst_busy", {31'd0, if0.busy}, 32'd0);
    check("rst_done", {31'd0, if0.done}, 32'd0);
    check("rst_words", {16'd0, if0.words_done}, 32'd0);
    check("rst_addr", if0.iomem_addr, 32'd0);
    check("rst_valid_b", {31'd0, if1.iomem_valid}, 32'd0);
    resetn = 1'b1;
    chk_en = 1'b1;

    // Three-word copy, one wait state per access.
    wait_states = 1;
    exp_rd(32'h0300_0000); exp_wr(32'h0400_0000, 32'h1300_0000);
    exp_rd(32'h0300_0004); exp_wr(32'h0400_0004, 32'h1300_0004);
    exp_rd(32'h0300_0008); exp_wr(32'h0400_0008, 32'h1300_0008);
    d0 = done_cnt;
    issue(32'h0300_0000, 32'h0400_0000, 16'd3);
    check("copy3_busy", {31'd0, m_busy}, 32'd1);
    wait_done(lat);
    finish_run("copy3", d0, 16'd3);

    // Zero length: done two cycles after start, no bus activity.
    v0 = valid_cycles; d0 = done_cnt;
    issue(32'h0300_0000, 32'h0400_0000, 16'd0);
    wait_done(lat);
    check("len0_latency", lat, 32'd2);
    finish_run("len0", d0, 16'd0);
    check("len0_no_valid", valid_cycles - v0, 32'd0);

    // Zero-wait copy across the address wrap; dst low bits are ignored.
    wait_states = 0;
    exp_rd(32'hFFFF_FFFC); exp_wr(32'h0000_0010, 32'h0FFF_FFFC);
    exp_rd(32'h0000_0000); exp_wr(32'h0000_0014, 32'h1000_0000);
    d0 = done_cnt;
    issue(32'hFFFF_FFFF, 32'h0000_0013, 16'd2);
    wait_done(lat);
    check("wrap_latency", lat, 32'd10);
    finish_run("wrap", d0, 16'd2);

    // Fixed destination instance.
    sel = 1'b1; wait_states = 1;
    for (int i = 0; i < 4; i++) begin
      exp_rd(32'h0300_0010 + 32'(4 * i));
      exp_wr(32'h0400_0000, 32'h1300_0010 + 32'(4 * i));
    end
    d0 = done_cnt;
    issue(32'h0300_0010, 32'h0400_0000, 16'd4);
    wait_done(lat);
    finish_run("fixdst", d0, 16'd4);
    sel = 1'b0;

    // Abort during the second read; a start while busy is ignored.
    exp_rd(32'h0500_0000); exp_wr(32'h0600_0000, 32'h1500_0000);
    exp_rd(32'h0500_0004); exp_wr(32'h0600_0004, 32'h1500_0004);
    d0 = done_cnt;
    issue(32'h0500_0000, 32'h0600_0000, 16'd8);
    n = 0;
    while (!(m_valid && m_wstrb == 4'h0 && m_addr == 32'h0500_0004) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_rd2_addr", m_addr, 32'h0500_0004);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    cmd_src = 32'h0700_0000; cmd_dst = 32'h0700_1000; cmd_len = 16'd5;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    wait_done(lat);
    finish_run("abort", d0, 16'd2);

    // Reset while a write is waiting for ready.
    wait_states = 0; hold_wr = 1'b1;
    exp_rd(32'h0800_0000);
    issue(32'h0800_0000, 32'h0900_0000, 16'd2);
    n = 0;
    while (!(m_valid && m_wstrb == 4'hF) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_wr_pending", {28'd0, m_wstrb}, 32'hF);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    d0 = done_cnt; v0 = valid_cycles;
    check("rstmid_valid", {31'd0, m_valid}, 32'd0);
    check("rstmid_busy", {31'd0, m_busy}, 32'd0);
    check("rstmid_words", {16'd0, m_words}, 32'd0);
    @(negedge clk);
    resetn = 1'b1; hold_wr = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_no_done", done_cnt - d0, 32'd0);
    check("rstmid_no_valid", valid_cycles - v0, 32'd0);
    check("rstmid_queue_empty", exp_q.size(), 32'd0);

`ifdef IOMEM_DMA_TIMEOUT_EN
    // Responder that never answers: valid held 255 cycles, then error.
    never_ready = 1'b1;
    v0 = valid_cycles; d0 = done_cnt;
    issue(32'h0A00_0000, 32'h0B00_0000, 16'd1);
    wait_done(lat);
    finish_run("tmo", d0, 16'd0);
    check("tmo_valid_cycles", valid_cycles - v0, 32'd255);
    check("tmo_error", {31'd0, if0.error}, 32'd1);
    never_ready = 1'b0;
    exp_rd(32'h0C00_0000); exp_wr(32'h0D00_0000, 32'h1C00_0000);
    d0 = done_cnt;
    issue(32'h0C00_0000, 32'h0D00_0000, 16'd1);
    check("tmo_error_cleared", {31'd0, if0.error}, 32'd0);
    wait_done(lat);
    finish_run("tmo_next", d0, 16'd1);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/iomem_dma.md
IOMEM_DMA -- requirements
Module: iomem_dma

Interface
REQ-001 The block SHALL provide parameter DST_INC, default 1, meaning 1 = destination address advances 4 per word and 0 = destination address stays fixed (FIFO-style peripheral).
REQ-002 The block SHALL provide parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles a request waits for iomem_ready (used only with the Configuration feature).
REQ-003 The block SHALL use clk, input, 1 bit, as its clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL use resetn, input, 1 bit, as its reset: synchronous, active-low.
REQ-005 cmd_start input 1: one-cycle pulse requesting a copy.
REQ-006 cmd_abort input 1: stop the copy at the next word boundary.
REQ-007 cmd_src input 32: source byte address; bits [1:0] ignored.
REQ-008 cmd_dst input 32: destination byte address; bits [1:0] ignored.
REQ-009 cmd_len input 16: word count.
REQ-010 busy output 1: a copy is in progress.
REQ-011 done output 1: one-cycle completion pulse.
REQ-012 words_done output 16: number of words written so far in the current or last copy.
REQ-013 iomem_valid output 1, iomem_wstrb output 4, iomem_addr output 32, iomem_wdata output 32: initiator side of the iomem bus.
REQ-014 iomem_ready input 1, iomem_rdata input 32: responder side of the iomem bus.

Function
REQ-015 The FSM SHALL have the states IDLE, RD, RD_GAP, WR, WR_GAP and FIN.
REQ-016 IDLE: cmd_start=1 SHALL latch src, dst and len with bits [1:0] forced to 0, clear words_done, set busy, and go to RD next cycle, or to FIN if len=0.
REQ-017 cmd_start SHALL be ignored when the FSM is not in IDLE.
REQ-018 RD SHALL drive iomem_valid=1, iomem_wstrb=0 and iomem_addr=src, held stable until iomem_ready is sampled 1.
REQ-019 A handshake SHALL complete on a rising edge where iomem_valid=1 and iomem_ready=1.
REQ-020 On a read handshake the block SHALL capture iomem_rdata into the data buffer, drop iomem_valid on that same edge, advance src by 4, and go to RD_GAP.
REQ-021 The GAP states SHALL hold iomem_valid=0 for exactly one cycle, so that a responder pulsing ready for one cycle never double-acknowledges.
REQ-022 RD_GAP SHALL proceed to WR.
REQ-023 WR SHALL drive iomem_valid=1, iomem_wstrb=4'hF, iomem_addr=dst and iomem_wdata=buffer, held stable until the handshake completes.
REQ-024 On a write handshake the block SHALL drop iomem_valid, increment words_done, advance dst by 4 if DST_INC=1, and go to WR_GAP.
REQ-025 WR_GAP SHALL go to FIN if words_done=len or if abort is pending, and otherwise to RD.
REQ-026 cmd_abort SHALL set a sticky pending flag, sampled in any non-IDLE state; an outstanding request SHALL never be withdrawn before its handshake completes.
REQ-027 The pending abort flag SHALL be cleared on entry to IDLE.
REQ-028 An abort raised while in RD SHALL still complete the full read-then-write of that word.
REQ-029 FIN SHALL pulse done=1 for one cycle, clear busy, and return to IDLE; cmd_start in FIN is ignored.
REQ-030 Address arithmetic SHALL be modulo 2^32, wrapping 32'hFFFFFFFC to 0.
REQ-031 iomem_addr and iomem_wstrb SHALL be 0 whenever iomem_valid=0.
REQ-032 Per-word throughput SHALL be 4 cycles with zero-wait responders; the minimum latency from cmd_start to done for len=N is 4N+2 cycles.

Reset
REQ-033 While resetn=0 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL be 0, including iomem_valid, busy, done and words_done.
REQ-034 A reset asserted mid-transfer SHALL abandon the copy; no bus request is issued after the reset edge and no done pulse is produced.

Configuration
REQ-035 With IOMEM_DMA_TIMEOUT_EN defined, a wait counter SHALL clear on each request start and increment every cycle while iomem_valid=1 and iomem_ready=0.
REQ-036 With IOMEM_DMA_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL drop iomem_valid, set a sticky error output (1 bit, cleared by the next accepted cmd_start) and go to FIN.
REQ-037 Without IOMEM_DMA_TIMEOUT_EN, the error port and counter SHALL not exist and the block SHALL wait for iomem_ready indefinitely.

Verification
REQ-038 Copy: src=0x0300_0000, dst=0x0400_0000, len=3, with a 1-wait-state responder model -> 3 reads then 3 writes interleaved R/W, wstrb=F, data matches, words_done=3, single done pulse.
REQ-039 len=0 -> no iomem_valid ever asserted, done pulses 2 cycles after cmd_start.
REQ-040 DST_INC=0, len=4 -> all 4 writes go to address 0x0400_0000.
REQ-041 cmd_abort during the second read of len=8 -> the second write completes, words_done=2, done pulses; cmd_start while busy has no effect.
REQ-042 resetn low during a WR with ready withheld -> iomem_valid=0 and busy=0 after the edge, no done.
REQ-043 With IOMEM_DMA_TIMEOUT_EN defined, a responder that never asserts ready -> valid drops after 255 cycles, error=1, done pulses.
